// File: rtl/calc_alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential calculator ALU.
package calc_alu_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_INV = 2'b00;
  localparam op_t OP_ADD = 2'b01;
  localparam op_t OP_SUB = 2'b10;
  localparam op_t OP_MUL = 2'b11;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/calc_alu_seq_if.sv
// Operand/result handshake bundle between keypad capture, the ALU and the display path.
interface calc_alu_seq_if #(parameter int WIDTH = 16);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     num1;
  logic [WIDTH-1:0]     num2;
  logic [1:0]           op_selected;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   number_out;
  logic                 special_signal;
  logic                 err;

  modport master (
    output in_valid, num1, num2, op_selected, out_ready,
    input  in_ready, out_valid, number_out, special_signal, err
  );

  modport slave (
    input  in_valid, num1, num2, op_selected, out_ready,
    output in_ready, out_valid, number_out, special_signal, err
  );

endinterface

// File: rtl/calc_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module calc_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // The final product is offered combinationally during the last step so the
  // caller can capture it on the same edge that retires the step.
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_alu_seq.sv
// Handshaked calculator ALU: single-cycle add/sub/invalid, iterative multiply,
// sign-magnitude subtraction and a held result until the consumer takes it.
module calc_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  calc_alu_seq_if.slave bus
);

  import calc_alu_pkg::*;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 neg_q, neg_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH-1:0]     diff_w;
  logic                 a_lt_b;

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .clear_n   (clear_n),
    .start_i   (mul_start),
    .a_i       (bus.num1),
    .b_i       (bus.num2),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign sum_w  = {1'b0, bus.num1} + {1'b0, bus.num2};
  assign a_lt_b = bus.num1 < bus.num2;
  assign diff_w = a_lt_b ? (bus.num2 - bus.num1) : (bus.num1 - bus.num2);

  // in_ready stays low while reset is asserted so nothing is offered as accepted.
  assign bus.in_ready       = clear_n && (state_q == ST_IDLE);
  assign bus.out_valid      = valid_q;
  assign bus.number_out     = result_q;
  assign bus.special_signal = neg_q;
  assign bus.err            = err_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    neg_d     = neg_q;
    err_d     = err_q;
    valid_d   = valid_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          neg_d = 1'b0;
          err_d = 1'b0;
          case (bus.op_selected)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum_w};
              state_d  = ST_DONE;
              valid_d  = 1'b1;
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, diff_w};
              neg_d    = a_lt_b;
              state_d  = ST_DONE;
              valid_d  = 1'b1;
            end
            OP_MUL: begin
              result_d  = '0;
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = ST_DONE;
              valid_d  = 1'b1;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d = mul_product;
          state_d  = ST_DONE;
          valid_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed self-checking bench for calc_alu_seq at WIDTH=16.
module tb_calc_alu_seq;

  localparam int W = 16;

  logic clk;
  logic clear_n;
  int   checks;
  int   fails;

  calc_alu_seq_if #(.WIDTH(W)) bus ();

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for exactly one edge; caller ensures the DUT is idle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    bus.num1        = a;
    bus.num2        = b;
    bus.op_selected = op;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid    = 1'b0;
  endtask

  // Latency counted with the cycle right after the accept edge as 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.num1       = '0;
    bus.num2       = '0;
    bus.op_selected = 2'b00;
    bus.out_ready  = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %0b expected 0", bus.out_valid); end
    checks++;
    if (bus.number_out !== 32'd0) begin fails++; $display("[TB] FAIL reset_number_out got %0h expected 0", bus.number_out); end
    checks++;
    if (bus.special_signal !== 1'b0) begin fails++; $display("[TB] FAIL reset_special got %0b expected 0", bus.special_signal); end
    checks++;
    if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %0b expected 0", bus.err); end
    checks++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready got %0b expected 0", bus.in_ready); end
    clear_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_in_ready got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_add();
    int lat;
    start_op(16'd5, 16'd3, 2'b01);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin fails++; $display("[TB] FAIL add_latency got %0d expected 1", lat); end
    checks++;
    if (bus.number_out !== 32'd8) begin fails++; $display("[TB] FAIL add_result got %0d expected 8", bus.number_out); end
    checks++;
    if (bus.special_signal !== 1'b0 || bus.err !== 1'b0) begin
      fails++; $display("[TB] FAIL add_flags got special=%0b err=%0b expected 0 0", bus.special_signal, bus.err);
    end
    finish_op();
  endtask

  task automatic test_sub();
    logic [W-1:0] av [3] = '{16'd26, 16'd16, 16'd10};
    logic [W-1:0] bv [3] = '{16'd16, 16'd26, 16'd10};
    logic [31:0]  rv [3] = '{32'd10, 32'd10, 32'd0};
    logic         nv [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i], 2'b10);
      wait_valid(lat);
      checks++;
      if (bus.number_out !== rv[i] || bus.special_signal !== nv[i]) begin
        fails++;
        $display("[TB] FAIL sub_%0d got %0d neg=%0b expected %0d neg=%0b", i, bus.number_out, bus.special_signal, rv[i], nv[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_overflow_mul();
    int   lat;
    logic ready_seen;
    start_op(16'hFFFF, 16'd1, 2'b01);
    wait_valid(lat);
    checks++;
    if (bus.number_out !== 32'h0001_0000) begin fails++; $display("[TB] FAIL add_overflow got %0h expected 10000", bus.number_out); end
    finish_op();
    start_op(16'hFFFF, 16'hFFFF, 2'b11);
    lat = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
    checks++;
    if (lat !== W + 1) begin fails++; $display("[TB] FAIL mul_latency got %0d expected %0d", lat, W + 1); end
    checks++;
    if (bus.number_out !== 32'hFFFE_0001) begin fails++; $display("[TB] FAIL mul_max got %0h expected fffe0001", bus.number_out); end
    checks++;
    if (ready_seen !== 1'b0) begin fails++; $display("[TB] FAIL mul_in_ready got high expected low throughout"); end
    checks++;
    if (bus.special_signal !== 1'b0 || bus.err !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_flags got special=%0b err=%0b expected 0 0", bus.special_signal, bus.err);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int   lat;
    logic bad;
    bus.out_ready = 1'b0;
    start_op(16'd300, 16'd200, 2'b11);
    wait_valid(lat);
    bus.num1        = 16'd1;
    bus.num2        = 16'd1;
    bus.op_selected = 2'b01;
    bus.in_valid    = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.number_out !== 32'd60000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      fails++; $display("[TB] FAIL backpressure_hold got out=%0d valid=%0b ready=%0b expected 60000 1 0", bus.number_out, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.number_out !== 32'd60000) begin fails++; $display("[TB] FAIL backpressure_ignore got %0d expected 60000", bus.number_out); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL backpressure_release got valid=%0b ready=%0b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_invalid_midreset();
    int   lat;
    logic seen;
    start_op(16'd12, 16'd34, 2'b00);
    wait_valid(lat);
    checks++;
    if (bus.err !== 1'b1 || bus.number_out !== 32'd0 || bus.special_signal !== 1'b0) begin
      fails++; $display("[TB] FAIL invalid_op got err=%0b out=%0d neg=%0b expected 1 0 0", bus.err, bus.number_out, bus.special_signal);
    end
    finish_op();
    start_op(16'd7, 16'd9, 2'b11);
    repeat (4) tick();
    clear_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.number_out !== 32'd0) begin
      fails++; $display("[TB] FAIL midreset_outputs got valid=%0b ready=%0b out=%0d expected 0 0 0", bus.out_valid, bus.in_ready, bus.number_out);
    end
    tick();
    clear_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreset_idle got in_ready=%0b expected 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin fails++; $display("[TB] FAIL midreset_no_result got a result expected none"); end
    start_op(16'd7, 16'd9, 2'b11);
    wait_valid(lat);
    checks++;
    if (bus.number_out !== 32'd63 || bus.err !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_after_reset got %0d err=%0b expected 63 0", bus.number_out, bus.err);
    end
    finish_op();
  endtask

  task automatic test_operand_hold();
    int lat;
    bus.out_ready = 1'b0;
    start_op(16'd5, 16'd3, 2'b01);
    bus.num1 = 16'd100;
    tick();
    wait_valid(lat);
    checks++;
    if (bus.number_out !== 32'd8) begin fails++; $display("[TB] FAIL hold_add got %0d expected 8", bus.number_out); end
    finish_op();
    start_op(16'd12, 16'd11, 2'b11);
    bus.num1        = 16'd0;
    bus.num2        = 16'd999;
    bus.op_selected = 2'b10;
    wait_valid(lat);
    checks++;
    if (bus.number_out !== 32'd132 || lat !== W + 1) begin
      fails++; $display("[TB] FAIL hold_mul got %0d lat=%0d expected 132 lat=%0d", bus.number_out, lat, W + 1);
    end
    finish_op();
    start_op(16'd1234, 16'd0, 2'b11);
    wait_valid(lat);
    checks++;
    if (bus.number_out !== 32'd0 || lat !== W + 1) begin
      fails++; $display("[TB] FAIL mul_by_zero got %0d lat=%0d expected 0 lat=%0d", bus.number_out, lat, W + 1);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic [31:0]  ea, eb, exp_res;
    logic         exp_neg, exp_err;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      a  = W'($urandom);
      b  = (i % 4 == 0) ? a : W'($urandom);
      op = 2'($urandom_range(0, 3));
      ea = {16'd0, a};
      eb = {16'd0, b};
      exp_neg = 1'b0;
      exp_err = 1'b0;
      case (op)
        2'b01: exp_res = ea + eb;
        2'b10: begin
          exp_res = (a >= b) ? (ea - eb) : (eb - ea);
          exp_neg = (a < b);
        end
        2'b11: exp_res = ea * eb;
        default: begin
          exp_res = 32'd0;
          exp_err = 1'b1;
        end
      endcase
      start_op(a, b, op);
      wait_valid(lat);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.number_out !== exp_res || bus.special_signal !== exp_neg || bus.err !== exp_err) begin
        fails++;
        $display("[TB] FAIL b2b_%0d op=%0d a=%0d b=%0d got %0h neg=%0b err=%0b expected %0h neg=%0b err=%0b",
                 i, op, a, b, bus.number_out, bus.special_signal, bus.err, exp_res, exp_neg, exp_err);
      end
      finish_op();
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_add();
    test_sub();
    test_overflow_mul();
    test_backpressure();
    test_invalid_midreset();
    test_operand_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Parametrised successor to the calculator ALU.
- Adds a valid/ready handshake on both sides.
- Operand width is set by WIDTH.
- Adds an iterative shift-add multiply alongside add and subtract.
- Reports sign-magnitude subtraction results and flags an unsupported op.
- Sits between the operand/keypad capture logic and the display/BCD converter.

Parameters:
WIDTH, 16, operand width in bits (minimum 2).
CW, $clog2(WIDTH+1), multiply iteration counter width (local parameter, derived, not overridable).

Ports:
clk  in  1  system clock, all state updates on rising edge
clear_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and op presented
in_ready  out  1  block can accept an operation
num1  in  WIDTH  operand A, unsigned
num2  in  WIDTH  operand B, unsigned
op_selected  in  2  00 invalid, 01 add, 10 sub, 11 mul
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
number_out  out  2*WIDTH  result magnitude, zero-extended
special_signal  out  1  1 = result negative (sub with num1 < num2)
err  out  1  1 = op_selected was 00; number_out = 0

Behaviour:
Reset (clear_n low, asynchronous):
- state = IDLE; out_valid = 0; number_out = 0; special_signal = 0; err = 0.
- in_ready = 1 once clear_n is released.
- Applies mid-operation: any multiply in progress is abandoned and no result is produced.

States and transitions:
- IDLE:
  - in_ready = 1, combinational from state.
  - Accept when in_valid && in_ready at the rising edge; num1, num2 and op_selected are captured.
- Op 01 (add), next state DONE:
  - number_out = num1 + num2 (WIDTH+1 significant bits, upper bits 0).
  - special_signal = 0.
- Op 10 (sub), next state DONE:
  - num1 >= num2: number_out = num1 - num2, special_signal = 0.
  - num1 < num2: number_out = num2 - num1, special_signal = 1.
  - Equal operands: number_out = 0, special_signal = 0.
- Op 00 (invalid), next state DONE: number_out = 0, err = 1, special_signal = 0.
- Op 11 (mul), next state MUL:
  - Load multiplicand and multiplier; clear the accumulator and the iteration counter.
- MUL:
  - One shift-add step per cycle, WIDTH cycles in total; in_ready = 0.
  - After step WIDTH, number_out = num1 * num2 (full 2*WIDTH bits), special_signal = 0, err = 0; next state DONE.
- DONE:
  - out_valid = 1; number_out, special_signal and err are held stable.
  - When out_valid && out_ready at the edge: out_valid drops and the next state is IDLE.
  - While out_ready = 0 the result is held indefinitely; in_ready = 0.

Latency:
- add/sub/invalid: out_valid high 1 cycle after the accept edge.
- mul: out_valid high WIDTH+1 cycles after the accept edge.

Throughput: at most one op every 2 cycles (IDLE and DONE are not overlapped).

Input sampling: operands and op are sampled only at the accept edge. Changes to num1, num2 or op_selected afterwards do not affect the result in flight.

Outputs: all registered except in_ready. The err and special_signal flags are cleared at each new accept.

Corner cases:
- Multiply by 0 completes in the full WIDTH+1 cycles with result 0; there is no early exit.
- in_valid asserted in MUL or DONE is ignored; the producer must hold it until in_ready.

Decomposition:
Package calc_alu_pkg:
- OP_INV = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_MUL = 2'b11.
- State encoding IDLE, MUL, DONE.

Sub-module calc_mul_seq:
- Iterative unsigned shift-add multiplier, WIDTH parameter.
- Interface: start, a, b → done pulse, product[2*WIDTH].
- Shares clk/clear_n.
- The top level owns the handshake FSM, add/sub and result muxing.

Test Plan (WIDTH=16):
1. Reset then add: clear_n low 3 cycles, then num1=5, num2=3, op=01, in_valid=1, out_ready=1. Expected: out_valid 1 cycle after accept, number_out=8, special_signal=0, err=0. All outputs must be 0 during reset.
2. Subtract both directions: 26-16 → number_out=10, special_signal=0. 16-26 → number_out=10, special_signal=1. 10-10 → 0, special_signal=0.
3. Add overflow and max multiply:
   - 65535+1 → number_out=65536 (bit 16 set).
   - 65535*65535 → 32'hFFFE0001 exactly 17 cycles after accept; in_ready=0 throughout.
4. Backpressure: mul 300*200 with out_ready=0 for 10 cycles after out_valid. Expected: number_out stays 60000, out_valid stays 1, in_ready stays 0, and a new in_valid is ignored. Then out_ready=1 → IDLE next cycle.
5. Invalid op and mid-op reset:
   - op=00 → out_valid with err=1, number_out=0.
   - Start mul 7*9 and pulse clear_n low after 5 cycles. Expected: immediate out_valid=0, state IDLE, no result. Then 7*9 → 63.
6. Operand change after accept: start add 5+3, change num1 to 100 in the following cycle. Expected: result 8. Randomised back-to-back ops checked against a reference model.
